// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared constants, state encoding and lane helpers for mem_stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] JT_NONE = 2'b00;
    localparam logic [1:0] JT_JALR = 2'b01;
    localparam logic [1:0] JT_JAL  = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] s;
        s = 4'b0000;
        case (f3)
            F3_B:    s = 4'b0001 << lo;
            F3_H:    s = lo[1] ? 4'b1100 : 4'b0011;
            F3_W:    s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    // Narrow stores replicate into every lane so the strobe alone selects the bytes.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        w = d;
        case (f3)
            F3_B:    w = {4{d[7:0]}};
            F3_H:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic is_load);
        logic m;
        m = 1'b0;
        case (f3)
            F3_H:    m = lo[0];
            F3_HU:   m = is_load & lo[0];
            F3_W:    m = (lo != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Selects and sign/zero-extends the addressed byte or half of a read word.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        data = 32'd0;
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_W:    data = rdata;
            F3_BU:   data = {24'd0, byte_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Pipeline MEM stage: issues data-memory requests, aligns loads,
//               registers MEM/WB values. Optional macro MEM_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       ex_pc,
    input  logic [XLEN-1:0]   ALUResult,
    input  logic [XLEN-1:0]   storeData,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [2:0]        funct3,
    input  logic              memToReg,
    input  logic              regWrite,
    input  logic [1:0]        jumpType,
    input  logic [4:0]        rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready,
    output logic              wb_valid,
    output logic [31:0]       wb_pc,
    output logic [XLEN-1:0]   wb_ALUResult,
    output logic [XLEN-1:0]   wb_dataFromRAM,
    output logic              wb_memToReg,
    output logic              wb_regWrite,
    output logic [1:0]        wb_jumpType,
    output logic [4:0]        wb_rd
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic              wb_misalign
`endif
);

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;

    // Sideband of the in-flight memory op, held until mem_ready.
    logic              is_load_q, is_load_d;
    logic [2:0]        f3_q, f3_d;
    logic [31:0]       pc_q, pc_d;
    logic [XLEN-1:0]   alu_q, alu_d;
    logic              mtr_q, mtr_d;
    logic              rw_q, rw_d;
    logic [1:0]        jt_q, jt_d;
    logic [4:0]        rd_q, rd_d;

    logic              wb_valid_q, wb_valid_d;
    logic [31:0]       wb_pc_q, wb_pc_d;
    logic [XLEN-1:0]   wb_alu_q, wb_alu_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              wb_mtr_q, wb_mtr_d;
    logic              wb_rw_q, wb_rw_d;
    logic [1:0]        wb_jt_q, wb_jt_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              wb_mis_q, wb_mis_d;

    logic              mem_op;
    logic              misalign;
    logic [31:0]       load_data;

    assign mem_op = memRead | memWrite;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = mem_op & is_misaligned(funct3, ALUResult[1:0], memRead);
`else
    assign misalign = 1'b0;
`endif

    load_align u_load_align (
        .rdata   (mem_rdata),
        .addr_lo (alu_q[1:0]),
        .funct3  (f3_q),
        .data    (load_data)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        is_load_d   = is_load_q;
        f3_d        = f3_q;
        pc_d        = pc_q;
        alu_d       = alu_q;
        mtr_d       = mtr_q;
        rw_d        = rw_q;
        jt_d        = jt_q;
        rd_d        = rd_q;
        wb_valid_d  = 1'b0;
        wb_pc_d     = wb_pc_q;
        wb_alu_d    = wb_alu_q;
        wb_data_d   = wb_data_q;
        wb_mtr_d    = wb_mtr_q;
        wb_rw_d     = wb_rw_q;
        wb_jt_d     = wb_jt_q;
        wb_rd_d     = wb_rd_q;
        wb_mis_d    = wb_mis_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (mem_op && !misalign) begin
                        state_d     = REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = memWrite;
                        mem_addr_d  = {ALUResult[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = store_lanes(funct3, storeData);
                        mem_wstrb_d = memWrite ? store_strb(funct3, ALUResult[1:0]) : 4'b0000;
                        is_load_d   = memRead;
                        f3_d        = funct3;
                        pc_d        = ex_pc;
                        alu_d       = ALUResult;
                        mtr_d       = memToReg;
                        rw_d        = regWrite;
                        jt_d        = jumpType;
                        rd_d        = rd;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_pc_d    = ex_pc;
                        wb_alu_d   = ALUResult;
                        wb_data_d  = '0;
                        wb_mtr_d   = memToReg;
                        wb_rw_d    = regWrite & ~misalign;
                        wb_jt_d    = jumpType;
                        wb_rd_d    = rd;
                        wb_mis_d   = misalign;
                    end
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_pc_d    = pc_q;
                    wb_alu_d   = alu_q;
                    wb_data_d  = is_load_q ? load_data : '0;
                    wb_mtr_d   = mtr_q;
                    wb_rw_d    = rw_q;
                    wb_jt_d    = jt_q;
                    wb_rd_d    = rd_q;
                    wb_mis_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 4'b0000;
            is_load_q   <= 1'b0;
            f3_q        <= 3'b000;
            pc_q        <= 32'd0;
            alu_q       <= '0;
            mtr_q       <= 1'b0;
            rw_q        <= 1'b0;
            jt_q        <= JT_NONE;
            rd_q        <= 5'd0;
            wb_valid_q  <= 1'b0;
            wb_pc_q     <= 32'd0;
            wb_alu_q    <= '0;
            wb_data_q   <= '0;
            wb_mtr_q    <= 1'b0;
            wb_rw_q     <= 1'b0;
            wb_jt_q     <= JT_NONE;
            wb_rd_q     <= 5'd0;
            wb_mis_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            is_load_q   <= is_load_d;
            f3_q        <= f3_d;
            pc_q        <= pc_d;
            alu_q       <= alu_d;
            mtr_q       <= mtr_d;
            rw_q        <= rw_d;
            jt_q        <= jt_d;
            rd_q        <= rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_pc_q     <= wb_pc_d;
            wb_alu_q    <= wb_alu_d;
            wb_data_q   <= wb_data_d;
            wb_mtr_q    <= wb_mtr_d;
            wb_rw_q     <= wb_rw_d;
            wb_jt_q     <= wb_jt_d;
            wb_rd_q     <= wb_rd_d;
            wb_mis_q    <= wb_mis_d;
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_wstrb      = mem_wstrb_q;
    assign wb_valid       = wb_valid_q;
    assign wb_pc          = wb_pc_q;
    assign wb_ALUResult   = wb_alu_q;
    assign wb_dataFromRAM = wb_data_q;
    assign wb_memToReg    = wb_mtr_q;
    assign wb_regWrite    = wb_rw_q;
    assign wb_jumpType    = wb_jt_q;
    assign wb_rd          = wb_rd_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign wb_misalign    = wb_mis_q;
`else
    logic unused_mis;
    assign unused_mis = wb_mis_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage: transaction model plus directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [31:0] ex_pc, ALUResult, storeData;
    logic        memRead, memWrite;
    logic [2:0]  funct3;
    logic        memToReg, regWrite;
    logic [1:0]  jumpType;
    logic [4:0]  rd;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        wb_valid;
    logic [31:0] wb_pc, wb_ALUResult, wb_dataFromRAM;
    logic        wb_memToReg, wb_regWrite;
    logic [1:0]  wb_jumpType;
    logic [4:0]  wb_rd;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        wb_misalign;
`endif

    int n_vec = 0;
    int n_err = 0;

    mem_stage #(.ADDR_W(32), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ex_pc(ex_pc), .ALUResult(ALUResult), .storeData(storeData),
        .memRead(memRead), .memWrite(memWrite), .funct3(funct3),
        .memToReg(memToReg), .regWrite(regWrite), .jumpType(jumpType), .rd(rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_ALUResult(wb_ALUResult), .wb_dataFromRAM(wb_dataFromRAM),
        .wb_memToReg(wb_memToReg), .wb_regWrite(wb_regWrite),
        .wb_jumpType(wb_jumpType), .wb_rd(wb_rd)
`ifdef MEM_MISALIGN_TRAP_EN
        , .wb_misalign(wb_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference rules written directly from the instruction semantics.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        int b, h;
        b = int'((w >> (a[1:0] * 8)) & 32'hFF);
        h = int'((w >> (a[1] * 16)) & 32'hFFFF);
        case (f3)
            3'b000:  return (b > 127)   ? b - 256   : b;
            3'b001:  return (h > 32767) ? h - 65536 : h;
            3'b010:  return w;
            3'b100:  return b;
            3'b101:  return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'b000:  return 4'b0001 << a[1:0];
            3'b001:  return a[1] ? 4'b1100 : 4'b0011;
            3'b010:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return {24'd0, d[7:0]} * 32'h0101_0101;
            3'b001:  return {16'd0, d[15:0]} * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] a,
                                     input logic ld, input logic st);
`ifdef MEM_MISALIGN_TRAP_EN
        if (!(ld || st)) return 1'b0;
        if (f3 == 3'b010) return a[1:0] != 2'b00;
        if (f3 == 3'b001 || (ld && f3 == 3'b101)) return a[0];
        return 1'b0;
`else
        return 1'b0 & (f3[0] ^ a[0] ^ ld ^ st);
`endif
    endfunction

    // Transaction model
    logic        m_busy, m_load, m_wbv, m_wb_mtr, m_wb_rw, m_wb_mis, m_mtr, m_rw;
    logic [2:0]  m_f3;
    logic [31:0] m_addr, m_sd, m_pc, m_wb_pc, m_wb_alu, m_wb_data;
    logic [1:0]  m_jt, m_wb_jt;
    logic [4:0]  m_rd, m_wb_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_load <= 1'b0; m_wbv <= 1'b0;
            m_wb_pc <= 0; m_wb_alu <= 0; m_wb_data <= 0; m_wb_mtr <= 0;
            m_wb_rw <= 0; m_wb_jt <= 0; m_wb_rd <= 0; m_wb_mis <= 0;
            m_f3 <= 0; m_addr <= 0; m_sd <= 0; m_pc <= 0; m_mtr <= 0; m_rw <= 0;
            m_jt <= 0; m_rd <= 0;
        end else begin
            m_wbv <= 1'b0;
            if (!m_busy) begin
                if (in_valid) begin
                    if ((memRead || memWrite) && !ref_mis(funct3, ALUResult, memRead, memWrite)) begin
                        m_busy <= 1'b1; m_load <= memRead; m_f3 <= funct3;
                        m_addr <= ALUResult; m_sd <= storeData; m_pc <= ex_pc;
                        m_mtr <= memToReg; m_rw <= regWrite; m_jt <= jumpType; m_rd <= rd;
                    end else begin
                        m_wbv <= 1'b1; m_wb_pc <= ex_pc; m_wb_alu <= ALUResult;
                        m_wb_data <= 0; m_wb_mtr <= memToReg;
                        m_wb_rw <= regWrite && !ref_mis(funct3, ALUResult, memRead, memWrite);
                        m_wb_mis <= ref_mis(funct3, ALUResult, memRead, memWrite);
                        m_wb_jt <= jumpType; m_wb_rd <= rd;
                    end
                end
            end else if (mem_ready) begin
                m_busy <= 1'b0; m_wbv <= 1'b1; m_wb_pc <= m_pc; m_wb_alu <= m_addr;
                m_wb_data <= m_load ? ref_load(m_f3, m_addr, mem_rdata) : 32'd0;
                m_wb_mtr <= m_mtr; m_wb_rw <= m_rw; m_wb_jt <= m_jt; m_wb_rd <= m_rd;
                m_wb_mis <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
        chk("mem_req", {31'd0, mem_req}, {31'd0, m_busy});
        if (m_busy) begin
            chk("mem_we", {31'd0, mem_we}, {31'd0, !m_load});
            chk("mem_addr", mem_addr, m_addr & 32'hFFFF_FFFC);
            if (!m_load) begin
                chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, ref_strb(m_f3, m_addr)});
                if (ref_strb(m_f3, m_addr) != 4'b0000)
                    chk("mem_wdata", mem_wdata, ref_wdata(m_f3, m_sd));
            end
        end
        chk("wb_valid", {31'd0, wb_valid}, {31'd0, m_wbv});
        if (m_wbv) begin
            chk("wb_pc", wb_pc, m_wb_pc);
            chk("wb_ALUResult", wb_ALUResult, m_wb_alu);
            chk("wb_dataFromRAM", wb_dataFromRAM, m_wb_data);
            chk("wb_memToReg", {31'd0, wb_memToReg}, {31'd0, m_wb_mtr});
            chk("wb_regWrite", {31'd0, wb_regWrite}, {31'd0, m_wb_rw});
            chk("wb_jumpType", {30'd0, wb_jumpType}, {30'd0, m_wb_jt});
            chk("wb_rd", {27'd0, wb_rd}, {27'd0, m_wb_rd});
`ifdef MEM_MISALIGN_TRAP_EN
            chk("wb_misalign", {31'd0, wb_misalign}, {31'd0, m_wb_mis});
`endif
        end
    end

    task automatic set_in(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] sd,
                          input logic ld, input logic st, input logic [2:0] f3,
                          input logic mtr, input logic rw, input logic [1:0] jt,
                          input logic [4:0] r);
        in_valid = 1'b1; ex_pc = pc; ALUResult = alu; storeData = sd;
        memRead = ld; memWrite = st; funct3 = f3; memToReg = mtr; regWrite = rw;
        jumpType = jt; rd = r;
    endtask

    task automatic idle_in();
        in_valid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    endtask

    // Present an instruction for one edge (accepted there since the stage is idle).
    task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] sd,
                         input logic ld, input logic st, input logic [2:0] f3,
                         input logic mtr, input logic rw, input logic [1:0] jt,
                         input logic [4:0] r);
        set_in(pc, alu, sd, ld, st, f3, mtr, rw, jt, r);
        @(posedge clk); #1;
        idle_in();
    endtask

    // mem_ready is sampled at the dly-th edge after acceptance.
    task automatic finish(input int dly, input logic [31:0] rdata);
        repeat (dly - 1) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        mem_ready = 1'b1; mem_rdata = rdata;
        @(posedge clk); #1;
        mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b0; mem_rdata = 32'd0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_in();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst wb_pc", wb_pc, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // add then jal back-to-back
        set_in(32'h3C, 32'h5, 0, 0, 0, 3'b000, 0, 1, 2'b00, 5'd3);
        @(posedge clk); #1;
        set_in(32'h40, 32'h44, 0, 0, 0, 3'b000, 0, 1, 2'b10, 5'd1);
        @(negedge clk);
        chk("add wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("add wb_ALUResult", wb_ALUResult, 32'h5);
        @(posedge clk); #1 idle_in();
        @(negedge clk);
        chk("jal wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("jal wb_pc", wb_pc, 32'h40);
        chk("jal wb_jumpType", {30'd0, wb_jumpType}, 32'd2);

        // lb at 0x1003, ready after 3 cycles; junk instruction offered while busy
        issue(32'h100, 32'h1003, 0, 1, 0, 3'b000, 1, 1, 2'b00, 5'd5);
        set_in(32'h999, 32'h7, 0, 0, 0, 3'b000, 0, 1, 2'b00, 5'd9);
        finish(3, 32'h80FF_FF00);
        @(negedge clk);
        chk("lb wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("lb data", wb_dataFromRAM, 32'hFFFF_FF80);

        issue(32'h104, 32'h1002, 0, 1, 0, 3'b101, 1, 1, 2'b00, 5'd6);
        finish(1, 32'h8001_1234);
        @(negedge clk);
        chk("lhu data", wb_dataFromRAM, 32'h0000_8001);
        issue(32'h108, 32'h1002, 0, 1, 0, 3'b001, 1, 1, 2'b00, 5'd7);
        finish(2, 32'h8001_1234);
        @(negedge clk);
        chk("lh data", wb_dataFromRAM, 32'hFFFF_8001);

        // sb at 0x2001
        issue(32'h10C, 32'h2001, 32'h0000_00AB, 0, 1, 3'b000, 0, 0, 2'b00, 5'd0);
        @(negedge clk);
        chk("sb mem_wstrb", {28'd0, mem_wstrb}, 32'h2);
        chk("sb mem_wdata", mem_wdata, 32'hABAB_ABAB);
        chk("sb mem_we", {31'd0, mem_we}, 32'd1);
        finish(2, 32'h0);
        @(negedge clk);
        chk("sb wb_data", wb_dataFromRAM, 32'd0);

        issue(32'h110, 32'h3002, 32'h1234_CDEF, 0, 1, 3'b001, 0, 0, 2'b00, 5'd0);
        @(negedge clk);
        chk("sh mem_wstrb", {28'd0, mem_wstrb}, 32'hC);
        chk("sh mem_wdata", mem_wdata, 32'hCDEF_CDEF);
        finish(1, 32'h0);
        issue(32'h114, 32'h3004, 32'hCAFE_F00D, 0, 1, 3'b010, 0, 0, 2'b00, 5'd0);
        finish(1, 32'h0);
        issue(32'h118, 32'h3008, 32'h1111_2222, 0, 1, 3'b011, 0, 0, 2'b00, 5'd0);
        @(negedge clk);
        chk("bad-f3 mem_wstrb", {28'd0, mem_wstrb}, 32'h0);
        finish(2, 32'h0);
        issue(32'h11C, 32'h0100, 0, 1, 0, 3'b010, 1, 1, 2'b00, 5'd8);
        finish(1, 32'h1357_9BDF);
        issue(32'h120, 32'h0101, 0, 1, 0, 3'b100, 1, 1, 2'b00, 5'd10);
        finish(1, 32'h1357_9BDF);
        @(negedge clk);
        chk("lbu data", wb_dataFromRAM, 32'h0000_009B);

        // mem_ready while idle is ignored
        mem_ready = 1'b1;
        @(posedge clk); #1 mem_ready = 1'b0;
        @(negedge clk);
        chk("idle ready wb_valid", {31'd0, wb_valid}, 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
        issue(32'h130, 32'h1002, 0, 1, 0, 3'b010, 1, 1, 2'b00, 5'd4);
        @(negedge clk);
        chk("mis wb_misalign", {31'd0, wb_misalign}, 32'd1);
        chk("mis wb_regWrite", {31'd0, wb_regWrite}, 32'd0);
        chk("mis mem_req", {31'd0, mem_req}, 32'd0);
`endif

        // reset in the middle of a request
        issue(32'h140, 32'h4000, 0, 1, 0, 3'b010, 1, 1, 2'b00, 5'd11);
        @(negedge clk);
        chk("pre-rst mem_req", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst mem_req", {31'd0, mem_req}, 32'd0);
        chk("async rst in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("post-rst wb_valid", {31'd0, wb_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, sitting between EX and WB. Accepts one instruction per handshake from EX and issues the data-memory request for loads and stores. It waits on a ready-based memory interface, aligns and extends load data, and registers the MEM/WB pipeline values that feed the combinational writeback mux. Non-memory instructions pass through with one cycle of latency.

## Interface
Parameters:
- ADDR_W, 32, data-memory address width
- XLEN, 32, datapath width

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX presents an instruction
- in_ready  out  1  stage can accept; high only in IDLE
- ex_pc  in  32  instruction PC
- ALUResult  in  32  effective address (mem ops) or result
- storeData  in  32  rs2 value for stores
- memRead / memWrite  in  1 each  load / store; never both high
- funct3  in  3  access size/sign
- memToReg, regWrite  in  1 each  forwarded to WB
- jumpType  in  2  forwarded (01 jalr, 10 jal)
- rd  in  5  destination register
- mem_req  out  1  request valid, held until mem_ready
- mem_we  out  1  write request
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- mem_wdata  out  32  lane-shifted store data
- mem_wstrb  out  4  byte enables
- mem_rdata  in  32  read word, valid with mem_ready
- mem_ready  in  1  completes current request
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_pc, wb_ALUResult, wb_dataFromRAM  out  32 each  registered to WB
- wb_memToReg, wb_regWrite  out  1 each
- wb_jumpType  out  2
- wb_rd  out  5
- wb_misalign  out  1  only with MEM_MISALIGN_TRAP_EN

## Operation
- FSM states: IDLE, REQ. Reset -> IDLE.
- IDLE, in_valid=1, no mem op: capture fields into MEM/WB registers, wb_valid=1 next cycle, wb_dataFromRAM=0; stay IDLE.
- IDLE, in_valid=1, memRead or memWrite: latch address/data/funct3/sideband; go REQ; mem_req=1 from next cycle.
- REQ: mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb held stable. On mem_ready=1: load -> aligned/extended rdata into wb_dataFromRAM; store -> wb_dataFromRAM=0; wb_valid=1 next cycle; return to IDLE.
- Load select by funct3/addr[1:0]: 000 lb sign-extend byte, 001 lh sign-extend half (addr[1]), 010 lw, 100 lbu, 101 lhu zero-extend; other codes -> 0.
- Store: 000 sb strb=1<<addr[1:0], data byte replicated to all lanes; 001 sh strb=addr[1]?1100:0011, half replicated; 010 sw strb=1111; other codes strb=0000 (request still issued, no write).
- in_valid while not IDLE: ignored (EX must hold; in_ready=0).
- No backpressure from WB; wb_valid pulses unconditionally.

## Timing
- Reset values: in_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, wb_valid=0, all wb_* =0.
- Non-mem latency: accept at edge T -> wb_valid high during cycle T+1.
- Mem latency: accept at T; mem_req high from T+1; mem_ready sampled at edge R (R>=T+1 edges) -> wb_valid during R+1, mem_req low R+1, in_ready high R+1. Minimum 2 cycles.
- Back-to-back: new instruction accepted in the same cycle wb_valid pulses.
- Reset mid-REQ: mem_req drops immediately (async), request abandoned, no wb_valid.
- mem_ready while mem_req=0: ignored.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: lh/lhu/sh with addr[0]=1 or lw/sw with addr[1:0]!=0 issue no request; completes like non-mem op one cycle later with wb_misalign=1, wb_regWrite=0.
- Undefined: no check; low address bits ignored for alignment (lh uses addr[1], lw full word); wb_misalign port absent.

## Structure
- Package mem_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum {IDLE, REQ}, jumpType codes.
- Sub-module load_align: combinational rdata x addr[1:0] x funct3 -> 32-bit extended value; instantiated once.

## Test plan
- Reset mid-REQ: assert rst_n=0 with mem_req=1 -> all outputs 0, in_ready=1, no wb_valid after release.
- lb at 0x1003, mem_rdata=0x80FF_FF00, ready after 3 cycles -> wb_dataFromRAM=0xFFFF_FF80, wb_valid 1 cycle after ready.
- lhu at 0x1002, rdata=0x8001_1234 -> 0x0000_8001; lh same -> 0xFFFF_8001.
- sb at 0x2001, storeData=0x0000_00AB -> mem_wstrb=0010, mem_wdata=0xABAB_ABAB, mem_we=1 held until mem_ready.
- Back-to-back: add (ALUResult=0x5) then jal (pc=0x40) -> wb_valid on consecutive cycles, wb_jumpType=10, wb_pc=0x40.
- MEM_MISALIGN_TRAP_EN: lw at 0x1002 -> mem_req never high, wb_misalign=1, wb_regWrite=0 one cycle after accept.
